ysyx_210544_dcache_sync_scan: RTL and testbench
===============================================

YSYX_210544_DCACHE_SYNC_SCAN -- requirements
Module: ysyx_210544_dcache_sync_scan

Interface
REQ-001 Parameter WAYS, default 4, number of DCache ways; way id width is 2 bits.
REQ-002 Parameter BLKS, default 16, blocks per way; block id width is 4 bits.
REQ-003 Parameter SKIP_INVALID, default 1, when 1 lines with info[25]=0 produce no packet.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 i_sync_dcache_rreq  in  1  scan request from cache-sync engine, held until rack seen.
REQ-007 o_sync_dcache_rack  out  1  scan-complete pulse.
REQ-008 o_sync_dcache_rpackreq  out  1  packet valid, held until rpackack.
REQ-009 i_sync_dcache_rpackack  in  1  packet-accepted pulse, one cycle.
REQ-010 o_sync_dcache_rwayid  out  2  way id of packet.
REQ-011 o_sync_dcache_rblkid  out  4  block id of packet.
REQ-012 o_sync_dcache_rinfo  out  26  line info: [25] valid, [24] dirty, [23:0] tag.
REQ-013 o_sync_dcache_rdata  out  512  line data.
REQ-014 o_scan_ren  out  1  DCache array read enable.
REQ-015 o_scan_rwayid / o_scan_rblkid  out  2 / 4  DCache array read address.
REQ-016 i_scan_rinfo / i_scan_rdata  in  26 / 512  array read data, valid exactly 1 cycle after o_scan_ren.
REQ-017 o_scan_busy  out  1  high in every non-IDLE state; DCache blocks CPU-side accesses while high.

Function
REQ-018 States: IDLE, READ, WAIT, PACK, GAP, DONE, HOLD; index counter idx[5:0] = {way, blk}.
REQ-019 IDLE: i_sync_dcache_rreq=1 -> idx<=0, go READ.
REQ-020 READ: o_scan_ren=1 for one cycle with address = idx, go WAIT.
REQ-021 WAIT: capture i_scan_rinfo/rdata into packet registers; if SKIP_INVALID=1 and rinfo[25]=0, skip (see REQ-024), else go PACK.
REQ-022 PACK: o_sync_dcache_rpackreq=1, id/info/data outputs stable; on rpackack=1 drop rpackreq next cycle and go GAP.
REQ-023 GAP: one cycle with rpackreq=0 so consumer observes deassertion; then advance per REQ-024.
REQ-024 Advance: idx != WAYS*BLKS-1 -> idx<=idx+1, go READ; idx == last -> go DONE (no wrap).
REQ-025 DONE: o_sync_dcache_rack=1 for exactly one cycle with rpackreq=0, go HOLD.
REQ-026 HOLD: wait for i_sync_dcache_rreq=0, then IDLE; rreq still high does not restart a scan.
REQ-027 rack and rpackreq are never high in the same cycle.
REQ-028 rreq dropping in READ/WAIT/PACK/GAP aborts: next cycle rpackreq=0, state IDLE, no rack.
REQ-029 rpackack outside PACK is ignored.
REQ-030 Packet latency: first packet's rpackreq rises 2 cycles after rreq sampled in IDLE (READ, WAIT, PACK).
REQ-031 Full valid cache: 64 packets; per packet minimum 4 cycles plus consumer ack latency.

Reset
REQ-032 rst=0 asynchronously forces IDLE, idx=0, and all outputs 0 (rack, rpackreq, ids, info, data, ren, read address, busy).
REQ-033 Reset mid-scan discards in-progress packet; no partial rack after release.

Structure
REQ-034 State encodings, info field bit positions (VALID=25, DIRTY=24, TAG 23:0), line width 512 and id widths live in the shared defines file.
REQ-035 Single module, no sub-modules; packet registers and idx counter are internal.

Verification
REQ-036 Empty cache (all valid=0), rreq=1 -> no rpackreq, rack pulse after 64 READ/WAIT pairs (129 cycles after rreq), then HOLD until rreq=0.
REQ-037 Only way 2 blk 5 valid, tag 0x00ABCD, data pattern 0xA5.. -> one packet wayid=2, blkid=5, info=0x200ABCD, data matches; rack after.
REQ-038 All 64 lines valid, consumer acks 3 cycles after rpackreq -> 64 packets in idx order 0..63, each dropped 1 cycle after ack, rack exactly once.
REQ-039 rreq deasserted while rpackreq high on idx 10 -> rpackreq=0 next cycle, IDLE, no rack; new rreq restarts from idx 0.
REQ-040 rst=0 asserted mid-PACK -> all outputs 0 immediately (before next edge); after release state IDLE.
REQ-041 SKIP_INVALID=0, empty cache -> 64 packets each with info[25]=0, then rack.

Source files
------------

// File: rtl/ysyx_210544_dcache_sync_scan_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_210544_dcache_sync_scan_pkg
// Shared definitions for the DCache sync-scan engine: index/line widths,
// line-info field positions and the scan state encoding.
// ----------------------------------------------------------------------------
package ysyx_210544_dcache_sync_scan_pkg;

    localparam int unsigned WAY_W  = 2;
    localparam int unsigned BLK_W  = 4;
    localparam int unsigned IDX_W  = WAY_W + BLK_W;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned INFO_W = 26;

    // Line info layout: {valid, dirty, tag[23:0]}
    localparam int unsigned INFO_VALID  = 25;
    localparam int unsigned INFO_DIRTY  = 24;
    localparam int unsigned INFO_TAG_HI = 23;
    localparam int unsigned INFO_TAG_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PACK,
        S_GAP,
        S_DONE,
        S_HOLD
    } scan_state_e;

    function automatic logic info_valid(input logic [INFO_W-1:0] info);
        return info[INFO_VALID];
    endfunction

endpackage

// File: rtl/ysyx_210544_dcache_sync_scan.sv
// ----------------------------------------------------------------------------
// ysyx_210544_dcache_sync_scan
// Walks every DCache line in {way, blk} order, reads it from the array and
// hands each (valid) line to the cache-sync engine as a packet with a
// req/ack handshake, then reports completion with a one-cycle rack pulse.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_sync_dcache_rreq       scan request, held until rack is seen
//   o_sync_dcache_rack       scan-complete pulse
//   o_sync_dcache_rpackreq   packet valid, held until rpackack
//   i_sync_dcache_rpackack   packet accepted (one-cycle pulse)
//   o_sync_dcache_rwayid/rblkid/rinfo/rdata   packet contents
//   o_scan_ren, o_scan_rwayid, o_scan_rblkid  DCache array read port
//   i_scan_rinfo, i_scan_rdata                array read data (1 cycle later)
//   o_scan_busy              scan in progress; CPU accesses must stall
// ----------------------------------------------------------------------------
module ysyx_210544_dcache_sync_scan
    import ysyx_210544_dcache_sync_scan_pkg::*;
#(
    parameter int WAYS         = 4,
    parameter int BLKS         = 16,
    parameter int SKIP_INVALID = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_sync_dcache_rreq,
    output logic              o_sync_dcache_rack,
    output logic              o_sync_dcache_rpackreq,
    input  logic              i_sync_dcache_rpackack,
    output logic [WAY_W-1:0]  o_sync_dcache_rwayid,
    output logic [BLK_W-1:0]  o_sync_dcache_rblkid,
    output logic [INFO_W-1:0] o_sync_dcache_rinfo,
    output logic [LINE_W-1:0] o_sync_dcache_rdata,

    output logic              o_scan_ren,
    output logic [WAY_W-1:0]  o_scan_rwayid,
    output logic [BLK_W-1:0]  o_scan_rblkid,
    input  logic [INFO_W-1:0] i_scan_rinfo,
    input  logic [LINE_W-1:0] i_scan_rdata,
    output logic              o_scan_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WAYS * BLKS - 1);

    scan_state_e      state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;

    // The array address is the scan index itself; it only matters while
    // o_scan_ren is high, and idx resets to zero.
    assign o_scan_rwayid = idx[IDX_W-1:BLK_W];
    assign o_scan_rblkid = idx[BLK_W-1:0];

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            S_IDLE: begin
                if (i_sync_dcache_rreq) begin
                    idx_nxt   = '0;
                    state_nxt = S_READ;
                end
            end
            S_READ: state_nxt = S_WAIT;
            S_WAIT: begin
                if (SKIP_INVALID != 0 && !info_valid(i_scan_rinfo)) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_READ;
                    end
                end else begin
                    state_nxt = S_PACK;
                end
            end
            S_PACK: begin
                if (i_sync_dcache_rpackack) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_DONE: state_nxt = S_HOLD;
            S_HOLD: begin
                if (!i_sync_dcache_rreq) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Requester withdrawing mid-scan abandons it without a rack.
        if (!i_sync_dcache_rreq &&
            (state == S_READ || state == S_WAIT ||
             state == S_PACK || state == S_GAP)) begin
            state_nxt = S_IDLE;
        end
    end

    // Handshake/strobe outputs are registered from the next state so they
    // line up with the state they describe without combinational decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                  <= S_IDLE;
            idx                    <= '0;
            o_sync_dcache_rack     <= 1'b0;
            o_sync_dcache_rpackreq <= 1'b0;
            o_scan_ren             <= 1'b0;
            o_scan_busy            <= 1'b0;
            o_sync_dcache_rwayid   <= '0;
            o_sync_dcache_rblkid   <= '0;
            o_sync_dcache_rinfo    <= '0;
            o_sync_dcache_rdata    <= '0;
        end else begin
            state                  <= state_nxt;
            idx                    <= idx_nxt;
            o_sync_dcache_rack     <= (state_nxt == S_DONE);
            o_sync_dcache_rpackreq <= (state_nxt == S_PACK);
            o_scan_ren             <= (state_nxt == S_READ);
            o_scan_busy            <= (state_nxt != S_IDLE);
            if (state == S_WAIT) begin
                o_sync_dcache_rwayid <= idx[IDX_W-1:BLK_W];
                o_sync_dcache_rblkid <= idx[BLK_W-1:0];
                o_sync_dcache_rinfo  <= i_scan_rinfo;
                o_sync_dcache_rdata  <= i_scan_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_210544_dcache_sync_scan.sv
module tb_ysyx_210544_dcache_sync_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT with SKIP_INVALID=1 ----------------
    logic         rreq = 1'b0, rack, rpackreq, rpackack = 1'b0;
    logic [1:0]   rwayid;
    logic [3:0]   rblkid;
    logic [25:0]  rinfo;
    logic [511:0] rdata;
    logic         scan_ren, busy;
    logic [1:0]   scan_rwayid;
    logic [3:0]   scan_rblkid;
    logic [25:0]  scan_rinfo = '0;
    logic [511:0] scan_rdata = '0;

    ysyx_210544_dcache_sync_scan #(.WAYS(4), .BLKS(16), .SKIP_INVALID(1)) dut (
        .clk(clk), .rst(rst),
        .i_sync_dcache_rreq(rreq), .o_sync_dcache_rack(rack),
        .o_sync_dcache_rpackreq(rpackreq), .i_sync_dcache_rpackack(rpackack),
        .o_sync_dcache_rwayid(rwayid), .o_sync_dcache_rblkid(rblkid),
        .o_sync_dcache_rinfo(rinfo), .o_sync_dcache_rdata(rdata),
        .o_scan_ren(scan_ren), .o_scan_rwayid(scan_rwayid), .o_scan_rblkid(scan_rblkid),
        .i_scan_rinfo(scan_rinfo), .i_scan_rdata(scan_rdata), .o_scan_busy(busy)
    );

    // ---------------- DUT with SKIP_INVALID=0 ----------------
    logic         ns_rreq = 1'b0, ns_rack, ns_rpackreq, ns_rpackack = 1'b0;
    logic [1:0]   ns_rwayid;
    logic [3:0]   ns_rblkid;
    logic [25:0]  ns_rinfo;
    logic [511:0] ns_rdata;
    logic         ns_ren, ns_busy;
    logic [1:0]   ns_scan_rwayid;
    logic [3:0]   ns_scan_rblkid;
    logic [25:0]  ns_scan_rinfo = '0;
    logic [511:0] ns_scan_rdata = '0;

    ysyx_210544_dcache_sync_scan #(.WAYS(4), .BLKS(16), .SKIP_INVALID(0)) dut_ns (
        .clk(clk), .rst(rst),
        .i_sync_dcache_rreq(ns_rreq), .o_sync_dcache_rack(ns_rack),
        .o_sync_dcache_rpackreq(ns_rpackreq), .i_sync_dcache_rpackack(ns_rpackack),
        .o_sync_dcache_rwayid(ns_rwayid), .o_sync_dcache_rblkid(ns_rblkid),
        .o_sync_dcache_rinfo(ns_rinfo), .o_sync_dcache_rdata(ns_rdata),
        .o_scan_ren(ns_ren), .o_scan_rwayid(ns_scan_rwayid), .o_scan_rblkid(ns_scan_rblkid),
        .i_scan_rinfo(ns_scan_rinfo), .i_scan_rdata(ns_scan_rdata), .o_scan_busy(ns_busy)
    );

    // ---------------- DCache array models (1-cycle read latency) ----------------
    logic [25:0]  m_info [64];
    logic [511:0] m_data [64];

    always @(posedge clk) begin
        if (scan_ren) begin
            scan_rinfo <= m_info[{scan_rwayid, scan_rblkid}];
            scan_rdata <= m_data[{scan_rwayid, scan_rblkid}];
        end
        // Invalid-everywhere cache; tag and data carry the index so order is visible.
        if (ns_ren) begin
            ns_scan_rinfo <= {2'b01, 18'd0, ns_scan_rwayid, ns_scan_rblkid};
            ns_scan_rdata <= {8{58'd0, ns_scan_rwayid, ns_scan_rblkid}};
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scan consumer ----------------
    int           pk_n, bad_data, both_hi, bad_drop, rack_n, ren_n, first_pk_tick, order_bad;
    int           pk_idx [$];
    logic [1:0]   f_way;
    logic [3:0]   f_blk;
    logic [25:0]  f_info;
    logic [511:0] f_data;

    // Runs one scan on dut from the current negedge. Acks each packet ack_dly
    // cycles after it is first seen; optionally pulses ack during the WAIT
    // cycle of early_idx, and drops rreq on seeing packet abort_idx.
    task automatic run_scan(input int ack_dly, input int early_idx, input int abort_idx,
                            input int bound, output int ticks);
        int cnt = -1;
        int id;
        bit ack_on = 0, early_pend = 0, early_on = 0, stop = 0;
        pk_n = 0; bad_data = 0; both_hi = 0; bad_drop = 0; rack_n = 0; ren_n = 0;
        first_pk_tick = -1;
        pk_idx.delete();
        ticks = 0;
        while (!stop && rack_n == 0 && ticks < bound) begin
            @(negedge clk);
            ticks++;
            if (early_on) begin rpackack = 1'b0; early_on = 0; end
            if (early_pend) begin rpackack = 1'b1; early_on = 1; early_pend = 0; end
            if (scan_ren) begin
                ren_n++;
                if (int'({scan_rwayid, scan_rblkid}) == early_idx) early_pend = 1;
            end
            if (rack) rack_n++;
            if (rack && rpackreq) both_hi++;
            if (ack_on) begin
                rpackack = 1'b0;
                ack_on   = 0;
                cnt      = -1;
                if (rpackreq) bad_drop++;
            end else if (rpackreq) begin
                if (cnt < 0) begin
                    id = int'({rwayid, rblkid});
                    pk_idx.push_back(id);
                    if (pk_n == 0) begin
                        first_pk_tick = ticks;
                        f_way = rwayid; f_blk = rblkid; f_info = rinfo; f_data = rdata;
                    end
                    if (rinfo !== m_info[id] || rdata !== m_data[id]) bad_data++;
                    pk_n++;
                    cnt = 0;
                    if (id == abort_idx) begin rreq = 1'b0; stop = 1; end
                end else begin
                    cnt++;
                end
                if (!stop && cnt == ack_dly) begin rpackack = 1'b1; ack_on = 1; end
            end else begin
                cnt = -1;
            end
        end
    endtask

    task automatic fill_all_valid();
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = 32'(i);
            m_info[i] = {1'b1, w[0], w[23:0] ^ 24'h5A5A5A};
            m_data[i] = {16{w ^ 32'hDEADBEEF}};
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int t, hold_rack, ns_pk, ns_bad, ns_rk;
        logic [5:0]   nid;
        logic [511:0] nexp;

        // ---- reset state ----
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rack",     512'(rack), 512'(0));
        check("rst_rpackreq", 512'(rpackreq), 512'(0));
        check("rst_busy",     512'(busy), 512'(0));
        check("rst_ren",      512'(scan_ren), 512'(0));
        check("rst_ids",      512'({rwayid, rblkid, scan_rwayid, scan_rblkid}), 512'(0));
        check("rst_info",     512'(rinfo), 512'(0));
        check("rst_data",     rdata, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // ---- empty cache: only READ/WAIT pairs, then rack ----
        for (int i = 0; i < 64; i++) begin m_info[i] = '0; m_data[i] = '0; end
        rreq = 1'b1;
        run_scan(0, -1, -1, 300, t);
        check("empty_rack_lat", 512'(t), 512'(129));
        check("empty_no_pkt",   512'(pk_n), 512'(0));
        check("empty_ren_n",    512'(ren_n), 512'(64));
        @(negedge clk);
        check("empty_rack_pulse", 512'(rack), 512'(0));
        hold_rack = 0;
        repeat (4) begin @(negedge clk); if (rack || rpackreq) hold_rack++; end
        check("hold_no_restart", 512'(hold_rack), 512'(0));
        check("hold_busy", 512'(busy), 512'(1));
        rreq = 1'b0;
        @(negedge clk);
        check("hold_to_idle", 512'(busy), 512'(0));

        // ---- single valid line way 2 blk 5; stray ack in its WAIT cycle ----
        m_info[37] = 26'h200ABCD;
        m_data[37] = {64{8'hA5}};
        @(negedge clk);
        rreq = 1'b1;
        run_scan(2, 37, -1, 400, t);
        check("one_pk_n",   512'(pk_n), 512'(1));
        check("one_wayid",  512'(f_way), 512'(2));
        check("one_blkid",  512'(f_blk), 512'(5));
        check("one_info",   512'(f_info), 512'(26'h200ABCD));
        check("one_data",   f_data, {64{8'hA5}});
        check("one_rack_n", 512'(rack_n), 512'(1));
        rreq = 1'b0;
        repeat (2) @(negedge clk);

        // ---- all 64 valid, ack 3 cycles after rpackreq ----
        fill_all_valid();
        rreq = 1'b1;
        run_scan(3, -1, -1, 1000, t);
        order_bad = 0;
        foreach (pk_idx[i]) if (pk_idx[i] != i) order_bad++;
        check("full_pk_n",      512'(pk_n), 512'(64));
        check("full_order",     512'(order_bad), 512'(0));
        check("full_data",      512'(bad_data), 512'(0));
        check("full_drop",      512'(bad_drop), 512'(0));
        check("full_both_hi",   512'(both_hi), 512'(0));
        check("full_first_lat", 512'(first_pk_tick), 512'(3));
        check("full_rack_lat",  512'(t), 512'(449));
        @(negedge clk);
        check("full_rack_pulse", 512'(rack), 512'(0));
        rreq = 1'b0;
        repeat (2) @(negedge clk);

        // ---- abort while packet idx 10 is offered ----
        rreq = 1'b1;
        run_scan(0, -1, 10, 1000, t);
        check("abort_pk_n", 512'(pk_n), 512'(11));
        @(negedge clk);
        check("abort_rpackreq", 512'(rpackreq), 512'(0));
        check("abort_idle",     512'(busy), 512'(0));
        hold_rack = 0;
        repeat (4) begin @(negedge clk); if (rack) hold_rack++; end
        check("abort_no_rack", 512'(hold_rack), 512'(0));
        rreq = 1'b1;
        run_scan(0, -1, -1, 1000, t);
        check("restart_first", 512'(pk_idx.size() > 0 ? pk_idx[0] : -1), 512'(0));
        check("restart_pk_n",  512'(pk_n), 512'(64));
        check("restart_lat",   512'(t), 512'(257));
        rreq = 1'b0;
        repeat (2) @(negedge clk);

        // ---- asynchronous reset while a packet is offered ----
        rreq = 1'b1;
        t = 0;
        while (!rpackreq && t < 20) begin @(negedge clk); t++; end
        check("rstpk_reached", 512'(rpackreq), 512'(1));
        #2 rst = 1'b0;
        #1;
        check("rstpk_rpackreq", 512'(rpackreq), 512'(0));
        check("rstpk_busy",     512'(busy), 512'(0));
        check("rstpk_pkt",      512'({rwayid, rblkid, rinfo}), 512'(0));
        check("rstpk_data",     rdata, '0);
        @(negedge clk);
        rreq = 1'b0;
        rst  = 1'b1;
        hold_rack = 0;
        repeat (4) begin @(negedge clk); if (rack || busy) hold_rack++; end
        check("rstpk_no_rack", 512'(hold_rack), 512'(0));

        // ---- SKIP_INVALID=0 on an empty cache ----
        ns_rreq = 1'b1;
        ns_pk = 0; ns_bad = 0; ns_rk = 0; t = 0;
        while (ns_rk == 0 && t < 1000) begin
            @(negedge clk);
            t++;
            if (ns_rack) ns_rk++;
            if (ns_rpackack) begin
                ns_rpackack = 1'b0;
            end else if (ns_rpackreq) begin
                nid  = 6'(ns_pk);
                nexp = {8{58'd0, nid}};
                if (ns_rinfo !== {2'b01, 18'd0, nid} || {ns_rwayid, ns_rblkid} !== nid ||
                    ns_rdata !== nexp) ns_bad++;
                ns_pk++;
                ns_rpackack = 1'b1;
            end
        end
        check("noskip_pk_n",  512'(ns_pk), 512'(64));
        check("noskip_pkts",  512'(ns_bad), 512'(0));
        check("noskip_rack",  512'(ns_rk), 512'(1));
        check("noskip_lat",   512'(t), 512'(257));
        ns_rreq = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
